// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared state encoding, reset constants and default widths
//               for the PWM duty-cycle generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 8;

    // Wide enough for any practical WIDTH; users slice the low bits.
    localparam logic [63:0] PER_RST  = '1;
    localparam logic [63:0] DUTY_RST = '0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_presc.sv
`default_nettype none
// ============================================================================
// Module      : pwm_presc
// Description : Prescaler producing a one-clock tick every presc+1 clocks
//               while run is high; held at zero otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_presc
    import pwm_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] r_pcnt;

    // A presc reduced below r_pcnt intentionally lets the counter roll over.
    assign tick = run && (r_pcnt == presc);

    always_ff @(posedge ck) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (!run || tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESC_W'(1);
        end
    end

endmodule : pwm_presc
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gen
// Description : Double-buffered PWM generator; period/duty updates apply only
//               on a period boundary or when leaving IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   period_in,
    input  logic [WIDTH-1:0]   duty_in,
    input  logic               load,
    output logic               load_ack,
    output logic               pwm_d,
    output logic               period_end
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_per_p;
    logic [WIDTH-1:0]   r_duty_p;
    logic               r_pend;
    logic [WIDTH-1:0]   r_per_a;
    logic [WIDTH-1:0]   r_duty_a;
    logic [WIDTH-1:0]   r_cnt;
    logic               r_pwm_d;
    logic               r_load_ack;
    logic               r_period_end;

    logic               w_run;
    logic               w_tick;
    logic               w_wrap;
    logic               w_apply;

    // Dropping en leaves RUN on this edge, so it also gates ticks and output.
    assign w_run   = (r_state == RUN) && en;
    assign w_wrap  = w_tick && (r_cnt == r_per_a);
    assign w_apply = r_pend && (w_wrap || ((r_state == IDLE) && en));

    pwm_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .ck    (ck),
        .rst   (rst),
        .run   (w_run),
        .presc (presc),
        .tick  (w_tick)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state      <= IDLE;
            r_per_p      <= DUTY_RST[WIDTH-1:0];
            r_duty_p     <= DUTY_RST[WIDTH-1:0];
            r_pend       <= 1'b0;
            r_per_a      <= PER_RST[WIDTH-1:0];
            r_duty_a     <= DUTY_RST[WIDTH-1:0];
            r_cnt        <= '0;
            r_pwm_d      <= 1'b0;
            r_load_ack   <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_load_ack   <= w_apply;
            r_period_end <= w_wrap;
            r_pwm_d      <= w_run && (r_cnt < r_duty_a);

            if (w_apply) begin
                r_per_a  <= r_per_p;
                r_duty_a <= r_duty_p;
                r_pend   <= 1'b0;
            end
            // A load on an applying edge becomes the next pending set.
            if (load) begin
                r_per_p  <= period_in;
                r_duty_p <= duty_in;
                r_pend   <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_cnt <= '0;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pwm_d      = r_pwm_d;
    assign load_ack   = r_load_ack;
    assign period_end = r_period_end;

endmodule : pwm_gen
`default_nettype wire

// File: tb/tb_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_gen
// Description : Directed self-checking testbench for pwm_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_gen;

    logic       ck = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] presc;
    logic [7:0] period_in;
    logic [7:0] duty_in;
    logic       load;
    logic       load_ack;
    logic       pwm_d;
    logic       period_end;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ck = ~ck;

    pwm_gen #(
        .WIDTH   (8),
        .PRESC_W (8)
    ) dut (
        .ck         (ck),
        .rst        (rst),
        .en         (en),
        .presc      (presc),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .load       (load),
        .load_ack   (load_ack),
        .pwm_d      (pwm_d),
        .period_end (period_end)
    );

    // Cycle k = 0 is the first cycle after the IDLE->RUN edge.
    function automatic logic exp_pwm(int k, int per, int duty, int ps);
        int c;
        if (k < 1) return 1'b0;
        c = ((k - 1) / (ps + 1)) % (per + 1);
        return (c < duty);
    endfunction

    function automatic logic exp_pe(int k, int per, int ps);
        return (k > 0) && ((k % ((per + 1) * (ps + 1))) == 0);
    endfunction

    task automatic apply_reset();
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        repeat (2) @(negedge ck);
        rst  = 1'b0;
    endtask

    // Reset, load one set while idle, then raise en; next negedge is k = 0.
    task automatic start_run(input int per, input int duty, input int ps);
        apply_reset();
        presc     = 8'(ps);
        period_in = 8'(per);
        duty_in   = 8'(duty);
        load      = 1'b1;
        @(negedge ck);
        load      = 1'b0;
        en        = 1'b1;
    endtask

    task automatic test_reset();
        presc = 8'd0; period_in = 8'd0; duty_in = 8'd0;
        apply_reset();
        @(negedge ck);
        n_checks++;
        if (pwm_d !== 1'b0) begin
            n_fail++; $display("FAIL reset_pwm_d got %b exp 0", pwm_d);
        end
        n_checks++;
        if (load_ack !== 1'b0) begin
            n_fail++; $display("FAIL reset_load_ack got %b exp 0", load_ack);
        end
        n_checks++;
        if (period_end !== 1'b0) begin
            n_fail++; $display("FAIL reset_period_end got %b exp 0", period_end);
        end
    endtask

    task automatic test_basic();
        start_run(9, 3, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge ck);
            n_checks++;
            if (pwm_d !== exp_pwm(k, 9, 3, 0)) begin
                n_fail++; $display("FAIL basic_pwm k=%0d got %b exp %b", k, pwm_d, exp_pwm(k, 9, 3, 0));
            end
            n_checks++;
            if (period_end !== exp_pe(k, 9, 0)) begin
                n_fail++; $display("FAIL basic_period_end k=%0d got %b exp %b", k, period_end, exp_pe(k, 9, 0));
            end
            n_checks++;
            if (load_ack !== (k == 0)) begin
                n_fail++; $display("FAIL basic_load_ack k=%0d got %b exp %b", k, load_ack, (k == 0));
            end
        end
    endtask

    task automatic test_duty_extremes();
        int duties [2] = '{0, 10};
        foreach (duties[i]) begin
            start_run(9, duties[i], 0);
            for (int k = 0; k < 30; k++) begin
                @(negedge ck);
                n_checks++;
                if (pwm_d !== (duties[i] != 0 && k >= 1)) begin
                    n_fail++; $display("FAIL extreme_pwm duty=%0d k=%0d got %b exp %b", duties[i], k, pwm_d, (duties[i] != 0 && k >= 1));
                end
                n_checks++;
                if (period_end !== exp_pe(k, 9, 0)) begin
                    n_fail++; $display("FAIL extreme_period_end duty=%0d k=%0d got %b exp %b", duties[i], k, period_end, exp_pe(k, 9, 0));
                end
            end
        end
    endtask

    task automatic test_mid_load();
        start_run(9, 3, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge ck);
            n_checks++;
            if (pwm_d !== exp_pwm(k, 9, (k >= 11) ? 5 : 3, 0)) begin
                n_fail++; $display("FAIL midload_pwm k=%0d got %b exp %b", k, pwm_d, exp_pwm(k, 9, (k >= 11) ? 5 : 3, 0));
            end
            n_checks++;
            if (load_ack !== (k == 0 || k == 10)) begin
                n_fail++; $display("FAIL midload_load_ack k=%0d got %b exp %b", k, load_ack, (k == 0 || k == 10));
            end
            n_checks++;
            if (period_end !== exp_pe(k, 9, 0)) begin
                n_fail++; $display("FAIL midload_period_end k=%0d got %b exp %b", k, period_end, exp_pe(k, 9, 0));
            end
            if (k == 5) begin
                period_in = 8'd9; duty_in = 8'd5; load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        start_run(9, 3, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge ck);
            n_checks++;
            if (pwm_d !== exp_pwm(k, 9, (k >= 11) ? 7 : 3, 0)) begin
                n_fail++; $display("FAIL dblload_pwm k=%0d got %b exp %b", k, pwm_d, exp_pwm(k, 9, (k >= 11) ? 7 : 3, 0));
            end
            n_checks++;
            if (load_ack !== (k == 0 || k == 10)) begin
                n_fail++; $display("FAIL dblload_load_ack k=%0d got %b exp %b", k, load_ack, (k == 0 || k == 10));
            end
            period_in = 8'd9;
            load      = (k == 3 || k == 6);
            duty_in   = (k == 3) ? 8'd2 : 8'd7;
        end
        load = 1'b0;
    endtask

    task automatic test_prescaler();
        int highs = 0;
        start_run(9, 3, 3);
        for (int k = 0; k < 90; k++) begin
            @(negedge ck);
            if (k >= 1 && k <= 40 && pwm_d === 1'b1) highs++;
            n_checks++;
            if (pwm_d !== exp_pwm(k, 9, 3, 3)) begin
                n_fail++; $display("FAIL presc_pwm k=%0d got %b exp %b", k, pwm_d, exp_pwm(k, 9, 3, 3));
            end
            n_checks++;
            if (period_end !== exp_pe(k, 9, 3)) begin
                n_fail++; $display("FAIL presc_period_end k=%0d got %b exp %b", k, period_end, exp_pe(k, 9, 3));
            end
        end
        n_checks++;
        if (highs != 12) begin
            n_fail++; $display("FAIL presc_high_count got %0d exp 12", highs);
        end
    endtask

    task automatic test_reset_enable();
        start_run(9, 3, 0);
        repeat (3) @(negedge ck);
        n_checks++;
        if (pwm_d !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_pwm got %b exp 1", pwm_d);
        end
        rst = 1'b1;
        @(negedge ck);
        n_checks++;
        if ({pwm_d, load_ack, period_end} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_outputs got %b exp 000", {pwm_d, load_ack, period_end});
        end
        rst = 1'b0; en = 1'b0;
        period_in = 8'd9; duty_in = 8'd4; load = 1'b1;
        @(negedge ck);
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge ck);
            n_checks++;
            if (pwm_d !== exp_pwm(k, 9, 4, 0)) begin
                n_fail++; $display("FAIL en_pwm k=%0d got %b exp %b", k, pwm_d, exp_pwm(k, 9, 4, 0));
            end
            n_checks++;
            if (load_ack !== (k == 0)) begin
                n_fail++; $display("FAIL en_load_ack k=%0d got %b exp %b", k, load_ack, (k == 0));
            end
            n_checks++;
            if (period_end !== exp_pe(k, 9, 0)) begin
                n_fail++; $display("FAIL en_period_end k=%0d got %b exp %b", k, period_end, exp_pe(k, 9, 0));
            end
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ck);
            n_checks++;
            if (pwm_d !== 1'b0) begin
                n_fail++; $display("FAIL en_off_pwm k=%0d got %b exp 0", k, pwm_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_extremes();
        test_mid_load();
        test_back_to_back();
        test_prescaler();
        test_reset_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pwm_gen
`default_nettype wire
